// File: rtl/score_add_scheduler.sv
// Score add scheduler: arbitrates point requests into a FIFO and drains each entry to the
// digit-counter chain as bounded chunks with carry gaps. Define SCORE_SCHED_FIXED_PRIO_EN for fixed priority.
module score_add_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int PTS_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_STEP   = 7,
    parameter int GAP_CYCLES = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQ-1:0]                          req_valid,
    input  logic [NUM_REQ-1:0][PTS_W-1:0]               req_points,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic                                        game_over,
    output logic [2:0]                                  add_amount,
    output logic                                        busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]             fifo_level,
    output logic [PTS_W+$clog2(FIFO_DEPTH+1):0]         pending_points
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam int PEND_W = PTS_W + CNT_W + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [PTS_W-1:0]   mem [FIFO_DEPTH];
    logic [PTS_W-1:0]   residual, residual_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic [PEND_W-1:0]  pend;
    logic [2:0]         chunk;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any, can_accept, xfer, push, pop, emit;
    logic [PTS_W-1:0]   push_pts;

    // No full-FIFO bypass: a pop in the same cycle does not free a slot for a grant.
    assign can_accept = !reset && !game_over && (count != CNT_W'(FIFO_DEPTH));

`ifdef SCORE_SCHED_FIXED_PRIO_EN
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    // Scan offsets high to low so the nearest requester after rr_ptr is the last writer.
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
`endif

    always_comb begin
        req_ready = '0;
        if (grant_any && can_accept)
            req_ready[grant_idx] = 1'b1;
    end

    assign xfer     = grant_any && can_accept;
    assign push_pts = req_points[grant_idx];
    assign push     = xfer && (push_pts != '0);
    assign pop      = (state == S_IDLE) && (count != '0);
    assign emit     = (state == S_EMIT);
    assign chunk    = (residual > PTS_W'(MAX_STEP)) ? 3'(MAX_STEP) : residual[2:0];

    always_comb begin
        state_nxt    = state;
        residual_nxt = residual;
        gap_cnt_nxt  = gap_cnt;
        add_amount   = 3'd0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    residual_nxt = mem[rd_ptr];
                    state_nxt    = S_EMIT;
                end
            end
            S_EMIT: begin
                add_amount   = chunk;
                residual_nxt = residual - PTS_W'(chunk);
                if (residual_nxt == '0)
                    state_nxt = S_IDLE;
                else if (GAP_CYCLES == 0)
                    state_nxt = S_EMIT;
                else begin
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0)
                    state_nxt = S_EMIT;
                else
                    gap_cnt_nxt = gap_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            residual <= '0;
            gap_cnt  <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend     <= '0;
        end else begin
            state    <= state_nxt;
            residual <= residual_nxt;
            gap_cnt  <= gap_cnt_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            pend <= pend + (push ? PEND_W'(push_pts) : PEND_W'(0))
                         - (emit ? PEND_W'(chunk) : PEND_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_pts;
    end

    assign busy           = (count != '0) || (state != S_IDLE);
    assign fifo_level     = count;
    assign pending_points = pend;
endmodule

// File: tb/tb_score_add_scheduler.sv
// Bench for score_add_scheduler: directed scenarios plus randomized traffic against a
// queue-level reference model (entries expand into their expected output chunk stream).
module tb_score_add_scheduler;
    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0][7:0]  req_points;
    logic             game_over;
    logic [3:0]       rdy, rdy0;
    logic [2:0]       add_amount, amt0;
    logic             busy, busy0;
    logic [3:0]       fifo_level, lvl0;
    logic [12:0]      pending_points, pend0;

    int n_vec = 0;
    int n_miss = 0;

    // Reference model state
    int         m_q[$];
    int         m_out[$];
    int         m_ptr;
    int         e_gi;
    logic [3:0] e_ready;
    logic [2:0] e_add;
    logic       e_busy;
    logic [3:0] e_lvl;
    logic [12:0] e_pend;

    score_add_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_points(req_points),
        .req_ready(rdy), .game_over(game_over), .add_amount(add_amount), .busy(busy),
        .fifo_level(fifo_level), .pending_points(pending_points)
    );

    score_add_scheduler #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_points(req_points),
        .req_ready(rdy0), .game_over(game_over), .add_amount(amt0), .busy(busy0),
        .fifo_level(lvl0), .pending_points(pend0)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic expand(input int p);
        while (p > 0) begin
            int c;
            c = (p > 7) ? 7 : p;
            m_out.push_back(c);
            p -= c;
            if (p > 0) m_out.push_back(0);  // one gap cycle
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = '0; req_points = '0; game_over = 1'b0;
        m_q.delete(); m_out.delete(); m_ptr = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Move to the falling edge and derive this cycle's expected outputs from the model.
    task automatic settle();
        int s;
        @(negedge clk);
        e_gi = -1;
        e_ready = '0;
        if (!reset && !game_over && m_q.size() < 8)
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (e_gi < 0 && req_valid[i]) e_gi = i;
            end
        if (e_gi >= 0) e_ready[e_gi] = 1'b1;
        e_add  = (m_out.size() != 0) ? 3'(m_out[0]) : 3'd0;
        e_busy = (m_q.size() != 0) || (m_out.size() != 0);
        e_lvl  = 4'(m_q.size());
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        foreach (m_out[i]) s += m_out[i];
        e_pend = 13'(s);
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_out.size() != 0) void'(m_out.pop_front());
        else if (m_q.size() != 0) expand(m_q.pop_front());
        if (e_gi >= 0) begin
            if (req_points[e_gi] != 0) m_q.push_back(int'(req_points[e_gi]));
`ifndef SCORE_SCHED_FIXED_PRIO_EN
            m_ptr = (e_gi + 1) % 4;
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_points = '0; game_over = 1'b0;
        #12;
        n_vec++;
        if ({rdy, add_amount, busy, fifo_level, pending_points} !== 25'd0) begin
            n_miss++;
            $display("FAIL reset_state: got rdy=%b amt=%0d busy=%b lvl=%0d pend=%0d, want all 0",
                     rdy, add_amount, busy, fifo_level, pending_points);
        end
        req_valid = 4'hF;
        #1;
        n_vec++;
        if (rdy !== 4'b0000) begin
            n_miss++; $display("FAIL reset_ready: got %b want 0000", rdy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_q.delete(); m_out.delete(); m_ptr = 0;
        settle();
        n_vec++;
        if (rdy !== 4'b0001) begin
            n_miss++; $display("FAIL reset_rr_ptr: got %b want 0001", rdy);
        end
        advance();
    endtask

    task automatic test_single();
        int amt_tab[7]  = '{0, 7, 0, 7, 0, 6, 0};
        int pend_tab[7] = '{20, 20, 13, 13, 6, 6, 0};
        int busy_tab[7] = '{1, 1, 1, 1, 1, 1, 0};
        apply_reset();
        req_valid = 4'b0100; req_points[2] = 8'd20;
        settle();
        n_vec++;
        if (rdy !== 4'b0100) begin
            n_miss++; $display("FAIL single_ready: got %b want 0100", rdy);
        end
        advance();
        req_valid = '0;
        for (int c = 0; c < 7; c++) begin
            settle();
            n_vec++;
            if ({rdy, add_amount, busy, pending_points} !==
                {4'b0000, 3'(amt_tab[c]), 1'(busy_tab[c]), 13'(pend_tab[c])}) begin
                n_miss++;
                $display("FAIL single_seq cyc %0d: got rdy=%b amt=%0d busy=%b pend=%0d want rdy=0000 amt=%0d busy=%0d pend=%0d",
                         c + 1, rdy, add_amount, busy, pending_points, amt_tab[c], busy_tab[c], pend_tab[c]);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        int sum, exp_i;
        apply_reset();
        req_valid = 4'hF; req_points = {4{8'd1}};
        sum = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
`ifdef SCORE_SCHED_FIXED_PRIO_EN
            exp_i = 0;
`else
            exp_i = c % 4;
`endif
            n_vec++;
            if (rdy !== 4'(1 << exp_i)) begin
                n_miss++; $display("FAIL rr_grant %0d: got %b want %b", c, rdy, 4'(1 << exp_i));
            end
            sum += int'(add_amount);
            advance();
        end
        req_valid = '0;
        for (int c = 0; c < 60; c++) begin
            settle();
            sum += int'(add_amount);
            if (!busy) break;
            advance();
        end
        n_vec++;
        if (busy !== 1'b0 || sum != 8) begin
            n_miss++; $display("FAIL rr_total: got sum=%0d busy=%b want sum=8 busy=0", sum, busy);
        end
    endtask

    task automatic test_full_fifo();
        int grants, waited;
        bit full_ok;
        apply_reset();
        req_valid = 4'b0001; req_points[0] = 8'd50;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (rdy[0] !== 1'b1) break;
            grants++;
            advance();
        end
        n_vec++;
        if (grants != 9) begin
            n_miss++; $display("FAIL full_grants: got %0d want 9", grants);
        end
        full_ok = 1; waited = 0;
        while (rdy !== 4'b0001 && waited < 40) begin
            if (fifo_level !== 4'd8 || rdy !== 4'b0000) full_ok = 0;
            advance();
            settle();
            waited++;
        end
        n_vec++;
        if (!full_ok || waited == 0) begin
            n_miss++; $display("FAIL full_hold: got full_ok=%0d waited=%0d want full_ok=1 waited>0", full_ok, waited);
        end
        n_vec++;
        if (rdy !== 4'b0001 || fifo_level !== 4'd7) begin
            n_miss++; $display("FAIL full_resume: got rdy=%b lvl=%0d want rdy=0001 lvl=7", rdy, fifo_level);
        end
    endtask

    task automatic test_game_over();
        int sum;
        bit ready_ok;
        apply_reset();
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'(1 << i); req_points[i] = 8'd10;
            settle();
            n_vec++;
            if (rdy !== req_valid) begin
                n_miss++; $display("FAIL go_queue %0d: got %b want %b", i, rdy, req_valid);
            end
            sum += int'(add_amount);
            advance();
        end
        game_over = 1'b1; req_valid = 4'b0111;
        ready_ok = 1;
        for (int c = 0; c < 80; c++) begin
            settle();
            if (rdy !== 4'b0000) ready_ok = 0;
            sum += int'(add_amount);
            if (!busy) break;
            advance();
        end
        n_vec++;
        if (!ready_ok) begin
            n_miss++; $display("FAIL go_ready: got a grant while game_over, want none");
        end
        n_vec++;
        if (sum != 30 || busy !== 1'b0 || pending_points !== 13'd0) begin
            n_miss++; $display("FAIL go_drain: got sum=%0d busy=%b pend=%0d want 30 0 0", sum, busy, pending_points);
        end
        game_over = 1'b0;
    endtask

    task automatic test_zero_gap0();
        int amt_tab[5]  = '{0, 7, 7, 1, 0};
        int busy_tab[5] = '{1, 1, 1, 1, 0};
        apply_reset();
        req_valid = 4'b0001; req_points[0] = 8'd0;
        settle();
        n_vec++;
        if (rdy0 !== 4'b0001) begin
            n_miss++; $display("FAIL zero_ready: got %b want 0001", rdy0);
        end
        advance();
        req_points[0] = 8'd15;
        settle();
        n_vec++;
        if ({lvl0, busy0, pend0} !== 18'd0) begin
            n_miss++; $display("FAIL zero_discard: got lvl=%0d busy=%b pend=%0d want 0 0 0", lvl0, busy0, pend0);
        end
        advance();
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_vec++;
            if ({amt0, busy0} !== {3'(amt_tab[c]), 1'(busy_tab[c])}) begin
                n_miss++;
                $display("FAIL gap0_seq cyc %0d: got amt=%0d busy=%b want amt=%0d busy=%0d",
                         c, amt0, busy0, amt_tab[c], busy_tab[c]);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        int amt_tab[3]  = '{0, 5, 0};
        int busy_tab[3] = '{1, 1, 0};
        apply_reset();
        req_valid = 4'b0001; req_points[0] = 8'd30;
        settle(); advance();
        req_valid = 4'b0010; req_points[1] = 8'd9;
        settle(); advance();
        req_valid = '0;
        repeat (2) begin settle(); advance(); end
        settle();
        n_vec++;
        if (add_amount !== 3'd7 || fifo_level !== 4'd1) begin
            n_miss++; $display("FAIL areset_pre: got amt=%0d lvl=%0d want 7 1", add_amount, fifo_level);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({add_amount, busy, fifo_level, pending_points} !== 21'd0 || clk !== 1'b0) begin
            n_miss++;
            $display("FAIL areset_clear: got amt=%0d busy=%b lvl=%0d pend=%0d clk=%b want all 0",
                     add_amount, busy, fifo_level, pending_points, clk);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_q.delete(); m_out.delete(); m_ptr = 0;
        req_valid = 4'b0001; req_points[0] = 8'd5;
        settle();
        n_vec++;
        if (rdy !== 4'b0001) begin
            n_miss++; $display("FAIL areset_ready: got %b want 0001", rdy);
        end
        advance();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if ({add_amount, busy} !== {3'(amt_tab[c]), 1'(busy_tab[c])}) begin
                n_miss++;
                $display("FAIL areset_seq cyc %0d: got amt=%0d busy=%b want amt=%0d busy=%0d",
                         c, add_amount, busy, amt_tab[c], busy_tab[c]);
            end
            advance();
        end
    endtask

    task automatic test_random();
        int errs;
        apply_reset();
        errs = 0;
        for (int c = 0; c < 900; c++) begin
            if (c < 400) begin
                req_valid = 4'($urandom);
                for (int i = 0; i < 4; i++)
                    req_points[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
                game_over = ($urandom_range(0, 9) == 0);
            end else begin
                req_valid = '0; game_over = 1'b0;
            end
            settle();
            n_vec++;
            if ({rdy, add_amount, busy, fifo_level, pending_points} !==
                {e_ready, e_add, e_busy, e_lvl, e_pend}) begin
                n_miss++;
                if (errs++ < 10)
                    $display("FAIL rand cyc %0d: got rdy=%b amt=%0d busy=%b lvl=%0d pend=%0d want rdy=%b amt=%0d busy=%b lvl=%0d pend=%0d",
                             c, rdy, add_amount, busy, fifo_level, pending_points,
                             e_ready, e_add, e_busy, e_lvl, e_pend);
            end
            if (c >= 400 && !e_busy) break;
            advance();
        end
        n_vec++;
        if (busy !== 1'b0 || m_q.size() != 0 || m_out.size() != 0) begin
            n_miss++; $display("FAIL rand_drain: got busy=%b model_q=%0d want idle", busy, m_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_fifo();
        test_game_over();
        test_zero_gap0();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/score_add_scheduler.md
# score_add_scheduler

Sequences score additions into the digit-counter chain. Several game sources (enemy kills, bonuses, timer events) raise point requests of arbitrary size. The block arbitrates between them and buffers accepted requests in a FIFO. It then feeds the `add_amount` input of the score digit display as bounded per-cycle chunks, with idle gap cycles between chunks so carries can ripple through the per-digit up counters.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters.
- `PTS_W`, 8: width of a request's point value.
- `FIFO_DEPTH`, 8: number of buffered requests; power of two, ≥2.
- `MAX_STEP`, 7: largest chunk issued per cycle; must fit in 3 bits.
- `GAP_CYCLES`, 1: zero-chunk cycles inserted after every chunk; 0..15.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, NUM_REQ: requester i has a point request pending.
- `req_points`, in, NUM_REQ×PTS_W: point value of each requester.
- `req_ready`, out, NUM_REQ: one-hot or zero; high for the granted requester this cycle.
- `game_over`, in, 1: when high, new requests are refused.
- `add_amount`, out, 3: chunk presented to the digit counter chain this cycle.
- `busy`, out, 1: high whenever the FIFO is non-empty or the state is not IDLE.
- `fifo_level`, out, $clog2(FIFO_DEPTH+1): number of occupied FIFO entries.
- `pending_points`, out, PTS_W+$clog2(FIFO_DEPTH+1)+1: sum of all FIFO entries plus the residual of the entry being emitted.

## Operation
Arbitration:
- Round-robin among requesters with `req_valid` high.
- The search starts at the requester after the last granted one; the pointer resets to requester 0, so requester 0 has first priority.
- At most one grant per cycle.
- No grant when `fifo_level == FIFO_DEPTH` or when `game_over` is high. There is no full-FIFO bypass, even if a pop occurs in the same cycle.
- A transfer happens when `req_valid[i] & req_ready[i]`.
- A transfer with points == 0 is accepted (ready pulses) and discarded; nothing is pushed.

FIFO:
- Push on transfer; pop on the IDLE→EMIT transition.
- A simultaneous push and pop leaves `fifo_level` unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states:
- **IDLE**: `add_amount` = 0. If the FIFO is non-empty, pop, load `residual` with the entry, and go to EMIT.
- **EMIT**: `add_amount` = min(residual, MAX_STEP); `residual` decreases by that chunk. If the new residual is 0, go to IDLE. Otherwise go to GAP, or stay in EMIT when GAP_CYCLES = 0.
- **GAP**: `add_amount` = 0 for exactly GAP_CYCLES cycles, then go to EMIT.

Arithmetic:
- `residual` is PTS_W bits wide.
- `pending_points` is updated on every push, chunk and discard, with no overflow possible at this width.
- `game_over` does not stop draining: the queued and in-flight points are always emitted in full, so the final score is exact.

## Timing
- Reset values: `add_amount` = 0, `req_ready` = 0, `busy` = 0, `fifo_level` = 0, `pending_points` = 0, state IDLE, RR pointer 0.
- `req_ready` is combinational from `req_valid`, the registered FIFO count, `game_over` and the RR pointer.
- `add_amount` is decoded from registered state only; it has no combinational path from the inputs.
- Latency: a transfer at edge E0 is pushed at E0 and popped at E1. The first nonzero `add_amount` appears in the cycle after E1.
- An entry of P points occupies the output for c + (c−1)·GAP_CYCLES cycles, where c = ceil(P / MAX_STEP).
- Back-to-back entries: the block returns to IDLE for 1 cycle between entries. That cycle also serves as the gap.
- `reset` asserted mid-operation clears the FIFO, the residual and `pending_points` immediately, and drives `add_amount` to 0 with no clock required.

## Configuration
- `SCORE_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest index with valid wins and the RR pointer is removed.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single request, default parameters.** Reset, then requester 2 sends 20 points.
  - `req_ready` = 0100 for 1 cycle.
  - `add_amount` reads 7, 0, 7, 0, 6 starting 2 cycles later, then `busy` falls.
  - `pending_points` steps 20 → 13 → 6 → 0.
- **Round-robin fairness.** All four requesters hold valid with 1 point each for 8 cycles.
  - Grants go 0,1,2,3,0,1,2,3.
  - Total `add_amount` summed = 8.
  - With `SCORE_SCHED_FIXED_PRIO_EN` defined, requester 0 wins every grant.
- **Full FIFO.** Hold `req_valid`[0] with 50 points.
  - Exactly 9 grants occur before `req_ready` drops (8 FIFO entries plus the first entry popped).
  - `fifo_level` reads 8 and `req_ready` is 0 while full.
  - A grant resumes the cycle after the next pop.
- **Game over mid-drain.** Queue 3×10 points, then raise `game_over`.
  - `req_ready` stays 0.
  - Emission continues until the total emitted = 30 and `busy` = 0.
- **Zero-point request and GAP_CYCLES = 0.** A 0-point request is accepted, with `fifo_level` unchanged.
  - A 15-point request yields 7, 7, 1 on consecutive cycles.
- **Asynchronous reset mid-EMIT.** Assert `reset` between clock edges.
  - `add_amount`, `busy`, `fifo_level` and `pending_points` go to 0 without a clock edge.
  - After release, a new 5-point request emits a single chunk of 5.
